// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and types for the UART TX arbiter: FSM states, requester
// indices, byte counts and the round-robin pointer helper.
package uart_tx_arbiter_pkg;

  localparam int NUM_REQ  = 3;
  localparam int REQ_ALU  = 0;
  localparam int REQ_RF   = 1;
  localparam int REQ_STAT = 2;

  localparam logic [1:0] BYTES_NONE = 2'd0;
  localparam logic [1:0] BYTES_ONE  = 2'd1;
  localparam logic [1:0] BYTES_TWO  = 2'd2;

  localparam logic [1:0] PTR_RESET = 2'd0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_FREE = 2'd3
  } txarb_state_e;

  // Index of the requester that follows the one-hot winner, wrapping 2->0.
  function automatic logic [1:0] next_ptr(input logic [NUM_REQ-1:0] winner);
    if (winner[REQ_ALU])     return 2'd1;
    else if (winner[REQ_RF]) return 2'd2;
    else                     return 2'd0;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_req_picker.sv
// Combinational one-hot winner selection over the three response sources.
// TXARB_ROUND_ROBIN_EN selects round-robin from ptr; otherwise ALU > RF > STAT.
module txarb_req_picker
  import uart_tx_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
`ifdef TXARB_ROUND_ROBIN_EN
  input  logic [1:0]         ptr,
`endif
  output logic [NUM_REQ-1:0] winner
);

`ifdef TXARB_ROUND_ROBIN_EN
  logic [1:0] idx;
  logic       found;

  // Scan from ptr upward, wrapping, and keep the first requester hit.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 2'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    if (req[REQ_ALU])       winner[REQ_ALU]  = 1'b1;
    else if (req[REQ_RF])   winner[REQ_RF]   = 1'b1;
    else if (req[REQ_STAT]) winner[REQ_STAT] = 1'b1;
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX byte path between ALU, register-file and status responses.
// Optional build macro TXARB_ROUND_ROBIN_EN enables round-robin arbitration.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                    TxArb_CLK,
  input  logic                    TxArb_RST,
  input  logic [NUM_REQ-1:0]      TxArb_Req,
  input  logic [2*DATA_WIDTH-1:0] TxArb_ALU_Data,
  input  logic [DATA_WIDTH-1:0]   TxArb_RF_Data,
  input  logic [DATA_WIDTH-1:0]   TxArb_Stat_Data,
  input  logic                    TxArb_Busy,
  output logic [NUM_REQ-1:0]      TxArb_Grant,
  output logic [DATA_WIDTH-1:0]   TxArb_TX_Pdata,
  output logic                    TxArb_TX_Data_Valid,
  output logic                    TxArb_Done,
  output logic                    TxArb_Timeout
);

  localparam int              CNT_W    = $clog2(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  txarb_state_e              state_q, state_d;
  logic [2*DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [1:0]                bytes_q, bytes_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic [DATA_WIDTH-1:0]     pdata_q, pdata_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      timeout_q, timeout_d;
  logic [NUM_REQ-1:0]        winner;

`ifdef TXARB_ROUND_ROBIN_EN
  logic [1:0]                ptr_q, ptr_d;
`endif

  txarb_req_picker u_picker (
    .req    (TxArb_Req),
`ifdef TXARB_ROUND_ROBIN_EN
    .ptr    (ptr_q),
`endif
    .winner (winner)
  );

  always_comb begin
    // NOTE: every variable gets its hold/idle value first so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    bytes_d   = bytes_q;
    cnt_d     = cnt_q;
    grant_d   = '0;
    pdata_d   = pdata_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
`ifdef TXARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (TxArb_Req != '0 && !TxArb_Busy) begin
          grant_d = winner;
          state_d = SEND;
`ifdef TXARB_ROUND_ROBIN_EN
          ptr_d   = next_ptr(winner);
`endif
          if (winner[REQ_ALU]) begin
            shift_d = TxArb_ALU_Data;
            bytes_d = BYTES_TWO;
          end else if (winner[REQ_RF]) begin
            shift_d = {{DATA_WIDTH{1'b0}}, TxArb_RF_Data};
            bytes_d = BYTES_ONE;
          end else begin
            shift_d = {{DATA_WIDTH{1'b0}}, TxArb_Stat_Data};
            bytes_d = BYTES_ONE;
          end
        end
      end

      SEND: begin
        pdata_d = shift_q[DATA_WIDTH-1:0];
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
        // Busy takes precedence over an expiring counter in the same cycle.
        if (TxArb_Busy) begin
          valid_d = 1'b0;
          state_d = WAIT_FREE;
        end else if (cnt_q == CNT_LAST) begin
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          bytes_d   = BYTES_NONE;
          state_d   = IDLE;
        end
      end

      WAIT_FREE: begin
        if (!TxArb_Busy) begin
          if (bytes_q == BYTES_TWO) begin
            shift_d = shift_q >> DATA_WIDTH;
            bytes_d = BYTES_ONE;
            state_d = SEND;
          end else begin
            bytes_d = BYTES_NONE;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge TxArb_CLK) begin
    if (!TxArb_RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bytes_q   <= BYTES_NONE;
      cnt_q     <= '0;
      grant_q   <= '0;
      pdata_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef TXARB_ROUND_ROBIN_EN
      ptr_q     <= PTR_RESET;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bytes_q   <= bytes_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      pdata_q   <= pdata_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
`ifdef TXARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign TxArb_Grant         = grant_q;
  assign TxArb_TX_Pdata      = pdata_q;
  assign TxArb_TX_Data_Valid = valid_q;
  assign TxArb_Done          = done_q;
  assign TxArb_Timeout       = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed frames plus randomized
// traffic against a transaction-level model (honours TXARB_ROUND_ROBIN_EN).
module tb_uart_tx_arbiter;

  localparam int DW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req;
  logic [15:0]   alu_data;
  logic [7:0]    rf_data;
  logic [7:0]    stat_data;
  logic          busy;
  logic [2:0]    grant;
  logic [7:0]    pdata;
  logic          valid;
  logic          done;
  logic          tmo;

  int n_cmp = 0;
  int n_bad = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(TO)) dut (
    .TxArb_CLK           (clk),
    .TxArb_RST           (rst),
    .TxArb_Req           (req),
    .TxArb_ALU_Data      (alu_data),
    .TxArb_RF_Data       (rf_data),
    .TxArb_Stat_Data     (stat_data),
    .TxArb_Busy          (busy),
    .TxArb_Grant         (grant),
    .TxArb_TX_Pdata      (pdata),
    .TxArb_TX_Data_Valid (valid),
    .TxArb_Done          (done),
    .TxArb_Timeout       (tmo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference winner: fixed priority ALU>RF>STAT, or round-robin from model_ptr.
  function automatic int pick(input logic [2:0] r);
    int res;
    int p;
    res = -1;
    for (int k = 0; k < 3; k++) begin
`ifdef TXARB_ROUND_ROBIN_EN
      p = (model_ptr + k) % 3;
`else
      p = k;
`endif
      if (res < 0 && r[p]) res = p;
    end
    return res;
  endfunction

  task automatic new_data(input int src);
    case (src)
      0:       alu_data  = 16'($urandom);
      1:       rf_data   = 8'($urandom);
      default: stat_data = 8'($urandom);
    endcase
  endtask

  // Entered on the first cycle Valid is expected high. d<0: Busy never rises.
  task automatic serve_byte(input logic [7:0] exp_b, input int d, input int h, output bit to);
    int hi;
    int spur;
    to   = 1'b0;
    hi   = 0;
    spur = 0;
    check("pdata", 32'(pdata), 32'(exp_b));
    if (d < 0) begin
      while (valid === 1'b1 && hi < 3 * TO) begin
        hi++;
        if (done || tmo || pdata !== exp_b) spur++;
        tick();
      end
      check("valid_len_timeout", 32'(hi), 32'(TO));
      check("timeout_pulse", 32'(tmo), 32'd1);
      check("no_done_on_timeout", 32'(done), 32'd0);
      to = 1'b1;
    end else begin
      for (int i = 0; i < d; i++) begin
        if (valid) hi++;
        if (done || tmo || pdata !== exp_b) spur++;
        tick();
      end
      if (valid) hi++;
      busy = 1'b1;
      check("valid_len", 32'(hi), 32'(d + 1));
      tick();
      check("valid_drop_on_busy", 32'(valid), 32'd0);
      for (int i = 1; i < h; i++) begin
        if (valid || done || tmo) spur++;
        tick();
      end
      busy = 1'b0;
      tick();
      if (tmo) spur++;
    end
    check("byte_spurious", 32'(spur), 32'd0);
  endtask

  // Entered with req driven and DUT idle; next edge must grant.
  task automatic do_frame(input int d0, input int h0, input int d1, input int h1);
    int win;
    bit to;
    logic [7:0] b0;
    logic [7:0] b1;
    win = pick(req);
    b0  = (win == 0) ? alu_data[7:0] : (win == 1) ? rf_data : stat_data;
    b1  = alu_data[15:8];
    tick();
    check("grant", 32'(grant), 32'(1 << win));
`ifdef TXARB_ROUND_ROBIN_EN
    model_ptr = (win + 1) % 3;
`endif
    req[win] = 1'b0;
    new_data(win);
    tick();
    check("grant_pulse", 32'(grant), 32'd0);
    check("valid_rise", 32'(valid), 32'd1);
    serve_byte(b0, d0, h0, to);
    if (!to && win == 0) begin
      check("no_done_mid_frame", 32'(done), 32'd0);
      tick();
      check("valid_rise_2nd", 32'(valid), 32'd1);
      serve_byte(b1, d1, h1, to);
    end
    if (!to) check("done_pulse", 32'(done), 32'd1);
  endtask

  task automatic quiet(input int k);
    int n;
    n = 0;
    repeat (k) begin
      tick();
      if (grant != 3'b0 || valid || done || tmo) n++;
    end
    check("quiet_after_frame", 32'(n), 32'd0);
  endtask

  initial begin
    int n;
    int win;
    int d0;
    int d1;
    logic [2:0] add;
    rst = 1'b0; req = 3'b0; busy = 1'b0;
    alu_data = 16'h0; rf_data = 8'h0; stat_data = 8'h0;
    repeat (3) tick();
    check("reset_outputs", 32'({grant, pdata, valid, done, tmo}), 32'd0);
    rst = 1'b1;
    tick();

    // ALU frame, LSB first, Busy 20 cycles after each Valid.
    alu_data = 16'hBEEF; req = 3'b001;
    do_frame(20, 3, 20, 3);

    // RF-only frame, then all three requesting at once.
    rf_data = 8'h33; req = 3'b010;
    do_frame(2, 1, 0, 0);
    alu_data = 16'h1234; rf_data = 8'h56; stat_data = 8'h78; req = 3'b111;
    do_frame(1, 1, 3, 2);
    do_frame(4, 2, 0, 0);
    do_frame(0, 1, 0, 0);

    // Busy in IDLE blocks grants.
    busy = 1'b1; rf_data = 8'h5A; req = 3'b010;
    n = 0;
    repeat (6) begin
      tick();
      if (grant != 3'b0) n++;
    end
    check("busy_blocks_grant", 32'(n), 32'd0);
    busy = 1'b0;
    do_frame(5, 2, 0, 0);

    // Timeout on a single-byte frame, then on the second ALU byte.
    stat_data = 8'hC3; req = 3'b100;
    do_frame(-1, 0, 0, 0);
    quiet(4);
    alu_data = 16'hA55A; req = 3'b001;
    do_frame(5, 2, -1, 0);
    quiet(4);

    // Busy arriving in the last counter cycle still wins.
    rf_data = 8'h81; req = 3'b010;
    do_frame(TO - 1, 2, 0, 0);

    // Reset in WAIT_ACK abandons the frame; pending request granted after release.
    alu_data = 16'h0F0F; rf_data = 8'hE1; req = 3'b011;
    win = pick(req);
    tick();
    check("grant_before_reset", 32'(grant), 32'(1 << win));
    req[win] = 1'b0;
    tick();
    check("valid_before_reset", 32'(valid), 32'd1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_mid_frame_outputs", 32'({grant, pdata, valid, done, tmo}), 32'd0);
    rst = 1'b1;
    model_ptr = 0;
    do_frame(3, 1, 3, 1);

    // Randomized traffic.
    for (int f = 0; f < 40; f++) begin
      add = (req == 3'b0) ? 3'($urandom_range(1, 7)) : (3'($urandom) & ~req);
      for (int s = 0; s < 3; s++) if (add[s]) new_data(s);
      req = req | add;
      d0 = int'($urandom_range(0, 20));
      d1 = int'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) d0 = -1;
      else if ($urandom_range(0, 7) == 0) d1 = -1;
      else if ($urandom_range(0, 9) == 0) d0 = TO - 1;
      do_frame(d0, int'($urandom_range(1, 4)), d1, int'($urandom_range(1, 4)));
    end
    while (req != 3'b0) do_frame(1, 1, 1, 1);
    quiet(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART TX byte path between three response sources in the REF_CLK domain: the ALU result (16-bit, sent as two bytes), the register-file read data, and a status byte.
- Drives the system-to-TX parallel data and valid into the TX data synchronizer.
- Paces bytes using the synchronized TX busy flag.
- Sits between the system controller's response sources and the TX-side data synchronizer.

Parameters:
DATA_WIDTH, 8, width of one TX byte
BUSY_TIMEOUT, 64, REF_CLK cycles to wait for busy to rise after issuing a byte before aborting the frame (must be >= 2)

Ports:
TxArb_CLK  input  1  system clock (REF_CLK domain)
TxArb_RST  input  1  synchronous active-low reset
TxArb_Req  input  3  level requests; bit0 ALU, bit1 RF, bit2 STAT
TxArb_ALU_Data  input  2*DATA_WIDTH  ALU result
TxArb_RF_Data  input  DATA_WIDTH  register read data
TxArb_Stat_Data  input  DATA_WIDTH  status byte
TxArb_Busy  input  1  TX busy, already synchronized to TxArb_CLK
TxArb_Grant  output  3  one-hot, 1-cycle pulse; source data latched this cycle
TxArb_TX_Pdata  output  DATA_WIDTH  byte toward TX synchronizer
TxArb_TX_Data_Valid  output  1  byte valid, held until busy observed
TxArb_Done  output  1  1-cycle pulse: frame fully transmitted
TxArb_Timeout  output  1  1-cycle pulse: frame aborted, busy never rose

Behaviour:
- Clock and reset: one clock, TxArb_CLK. Reset is synchronous and active-low (TxArb_RST=0 sampled on a TxArb_CLK edge).
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0.
- Reset mid-frame: the frame is abandoned silently. No Done, no Timeout, Valid drops on the reset edge.
- All outputs are registered.
- Request rule: a requester holds Req high and its data stable until it sees Grant, and drops Req in the cycle after Grant. Req still high after that is a new request.
- State IDLE: arbitrate only when Req!=0 and Busy=0.
  - Busy=1 in IDLE blocks all grants.
  - On arbitration, pulse Grant for the winner (one cycle after Req is sampled).
  - Latch data into a 2*DATA_WIDTH shift register; the 8-bit sources are zero-extended.
  - Load bytes_left: 2 for ALU, 1 otherwise.
  - Next state SEND.
- State SEND (1 cycle): Pdata=shift[DATA_WIDTH-1:0], Valid=1, counter cleared, next state WAIT_ACK. Valid therefore rises 2 cycles after Req is sampled.
- State WAIT_ACK: hold Valid and Pdata; counter increments each cycle.
  - Busy=1: Valid=0, next state WAIT_FREE.
  - Counter == BUSY_TIMEOUT-1 with Busy=0: Valid=0, Timeout pulse, remaining bytes discarded, next state IDLE.
  - Busy=1 in the timeout cycle: Busy wins.
- State WAIT_FREE: wait for Busy=0, then decrement bytes_left.
  - bytes_left was 2: shift right by DATA_WIDTH, next state SEND.
  - Otherwise: Done pulse, next state IDLE.
- Byte order: the ALU LSB byte is sent first, then the MSB byte.
- Frame atomicity: a frame is never interleaved. New requests wait in IDLE regardless of their priority.
- Default arbitration is fixed priority: ALU > RF > STAT.
- Done and Timeout are mutually exclusive per frame.
- The Grant→Done sequence is never re-entered before the block returns to IDLE.
- Counter width is clog2(BUSY_TIMEOUT); it saturates and never wraps.

Optional Feature:
- Macro: TXARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. After each Grant (whether or not the frame times out), the pointer moves to the index after the winner. The search starts at the pointer and wraps 2→0.
- Undefined: fixed priority ALU > RF > STAT, and no pointer register exists.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=0, SEND=1, WAIT_ACK=2, WAIT_FREE=3
  - requester indices: REQ_ALU=0, REQ_RF=1, REQ_STAT=2
  - NUM_REQ=3
  - byte-count constants
- Sub-module txarb_req_picker: combinational. Takes the request vector and pointer; returns a one-hot winner. Fixed-priority or round-robin selected by the macro.
- The FSM, shift register, counter and outputs stay in uart_tx_arbiter.

Test Plan:
- Reset mid-frame: TxArb_RST=0 during WAIT_ACK → next cycle all outputs 0, IDLE. A pending request is granted 1 cycle after reset releases.
- ALU frame: Req=001, ALU_Data=16'hBEEF, Busy pulses high 20 cycles after each Valid → Grant=001; Pdata=EF then BE, each with Valid held until Busy=1; Done once after the second Busy falls.
- Simultaneous requests: Req=111 with fixed priority → grants in order ALU, RF, STAT, each after the prior Done. With TXARB_ROUND_ROBIN_EN, the same traffic after an RF-only grant → STAT, then ALU, then RF.
- Busy gating: Busy=1 held in IDLE with Req=010 → no Grant until Busy=0, then Grant=010 the next cycle and Pdata=RF_Data (e.g. 8'h5A).
- Timeout: Req=100 and Busy stuck at 0, BUSY_TIMEOUT=64 → Valid high exactly 64 cycles, then Timeout pulse, no Done, IDLE.
- Timeout on the second ALU byte: the first byte completes and the second never sees Busy → Timeout pulse, no third byte, no Done.
